// File: rtl/mux_tree_pipe.sv
// ---------------------------------------------------------------------------
// mux_tree_pipe
//
// Purpose:
//   N:1 lane selector built as a binary tree of 2:1 stages with a register
//   after every tree level. Beats travel as a valid/ready stream. Each beat
//   carries all N lanes plus a select, and the chosen lane appears L=log2(N)
//   cycles later. Select bits are consumed LSB first: level k steers on
//   sel[k-1].
//
// Parameters:
//   N      number of input lanes (power of two, >= 2)
//   WIDTH  bits per lane
//   SELW   select width, $clog2(N) (not overridable)
//   L      number of tree levels, which is also the pipeline depth
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   input beat present
//   in_ready   block accepts a beat this cycle
//   in_data    N lanes, lane j = in_data[j*WIDTH +: WIDTH]
//   in_sel     lane index to forward with this beat
//   out_valid  output beat present
//   out_ready  downstream accepts the beat
//   out_data   selected lane
//   out_sel    select value that produced out_data
//
// Configuration:
//   MUX_TREE_PIPE_SCAN_EN  when defined, in_sel is ignored. An internal
//                          counter supplies the select and advances by one
//                          (mod N) on every accepted input beat.
// ---------------------------------------------------------------------------
module mux_tree_pipe #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(N),
  localparam int L    = SELW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]      in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  // All tree nodes live in one flat array. Level 1 comes first, then
  // level 2, and so on. The single root node sits at index N-2.
  localparam int NODES = N - 1;

  // First flat index of level k. It equals the number of nodes in levels
  // 1..k-1.
  function automatic int levelOffset(input int k);
    return N - (N >> (k - 1));
  endfunction

  logic [WIDTH-1:0] r_node [NODES];
  logic [SELW-1:0]  r_sel  [1:L];
  logic [L:1]       r_valid;

  logic [WIDTH-1:0] w_nodeNext [NODES];
  logic [SELW-1:0]  w_prevSel  [1:L];
  logic [L:1]       w_prevValid;
  logic [L:1]       w_ready;
  logic [SELW-1:0]  w_sel0;

`ifdef MUX_TREE_PIPE_SCAN_EN
  // The scan counter supplies the select for each new beat. It moves only
  // when a beat is actually accepted, so stalls do not skip lanes.
  logic [SELW-1:0] r_scanCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scanCnt <= '0;
    end else if (in_valid && w_ready[1]) begin
      r_scanCnt <= r_scanCnt + SELW'(1);
    end
  end

  assign w_sel0 = r_scanCnt;
`else
  assign w_sel0 = in_sel;
`endif

  // Ready ripples back from the output. A level can load whenever it is
  // empty, or whenever the level after it can take its contents this cycle.
  // This is how bubbles get squeezed out during a stall.
  always_comb begin
    logic v_carry;
    v_carry = out_ready;
    w_ready = '0;
    for (int k = L; k >= 1; k--) begin
      v_carry    = !r_valid[k] | v_carry;
      w_ready[k] = v_carry;
    end
  end

  // These are the valid and select values feeding each level. Level 1 takes
  // them from the input port. Every later level takes them from the register
  // of the level before it.
  always_comb begin
    w_prevValid    = '0;
    w_prevValid[1] = in_valid;
    w_prevSel[1]   = w_sel0;
    for (int k = 2; k <= L; k++) begin
      w_prevValid[k] = r_valid[k-1];
      w_prevSel[k]   = r_sel[k-1];
    end
  end

  // This block is the 2:1 mux tree. Node j of level k picks child 2j or
  // child 2j+1 using select bit k-1. That bit travels with the beat, so a
  // later change on in_sel cannot disturb a beat that is already inside.
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      w_nodeNext[i] = '0;
    end
    for (int j = 0; j < N / 2; j++) begin
      w_nodeNext[j] = w_sel0[0] ? in_data[(2*j+1)*WIDTH +: WIDTH]
                                : in_data[(2*j)*WIDTH +: WIDTH];
    end
    for (int k = 2; k <= L; k++) begin
      for (int j = 0; j < (N >> k); j++) begin
        w_nodeNext[levelOffset(k)+j] =
          w_prevSel[k][k-1] ? r_node[levelOffset(k-1)+2*j+1]
                            : r_node[levelOffset(k-1)+2*j];
      end
    end
  end

  // Every level advances as a unit (valid, select and its slice of nodes)
  // whenever its ready is high. A bubble moves forward exactly like a real
  // beat. Reset clears everything and drops any beats still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < NODES; i++) begin
        r_node[i] <= '0;
      end
      for (int k = 1; k <= L; k++) begin
        r_sel[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= L; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_prevValid[k];
          r_sel[k]   <= w_prevSel[k];
          for (int j = 0; j < (N >> k); j++) begin
            r_node[levelOffset(k)+j] <= w_nodeNext[levelOffset(k)+j];
          end
        end
      end
    end
  end

  assign in_ready  = w_ready[1];
  assign out_valid = r_valid[L];
  assign out_data  = r_node[NODES-1];
  assign out_sel   = r_sel[L];

endmodule
